// File: rtl/sdram_write_buffer.sv
// Posted-write FIFO feeding the SDRAM adapter write port, with a read-after-write
// hazard flag for CPU reads that hit a still-pending write.
module sdram_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          cpu_write_address,
    input  logic [DW-1:0]          cpu_write_data,
    input  logic                   cpu_write_valid,
    output logic                   cpu_write_ready,
    input  logic [AW-1:0]          cpu_read_address,
    output logic                   cpu_read_hazard,
    output logic [AW-1:0]          write_address,
    output logic [DW-1:0]          write_data,
    output logic                   write_address_valid,
    input  logic                   write_data_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_occupancy;
    logic          w_hazard;

    // The pointer MSB is the wrap phase: equal low bits mean empty or full.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
    assign w_push      = cpu_write_valid && !w_full;
    assign w_pop       = !w_empty && write_data_ready;
    assign w_occupancy = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            // NOTE: storage is reset too, so the adapter-facing address/data read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr[IW-1:0]] <= cpu_write_address;
                r_data[r_wr_ptr[IW-1:0]] <= cpu_write_data;
                r_wr_ptr                 <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Only slots between rd_ptr and wr_ptr are live; a same-cycle push is not yet stored.
    always_comb begin
        // NOTE: default first so no path leaves w_hazard unassigned (no latch).
        w_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW'(k) < w_occupancy) &&
                (r_addr[r_rd_ptr[IW-1:0] + IW'(k)] == cpu_read_address)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign cpu_write_ready     = !w_full;
    assign cpu_read_hazard     = w_hazard;
    assign write_address       = r_addr[r_rd_ptr[IW-1:0]];
    assign write_data          = r_data[r_rd_ptr[IW-1:0]];
    assign write_address_valid = !w_empty;
    assign occupancy           = w_occupancy;
    assign empty               = w_empty;

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Self-checking bench for sdram_write_buffer: directed scenarios plus random traffic,
// compared against a queue-based model of the posted-write buffer.
module tb_sdram_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic                   clk    = 1'b0;
    logic                   clk_en = 1'b1;
    logic                   reset  = 1'b1;
    logic [AW-1:0]          cpu_write_address = '0;
    logic [DW-1:0]          cpu_write_data    = '0;
    logic                   cpu_write_valid   = 1'b0;
    logic                   cpu_write_ready;
    logic [AW-1:0]          cpu_read_address  = '0;
    logic                   cpu_read_hazard;
    logic [AW-1:0]          write_address;
    logic [DW-1:0]          write_data;
    logic                   write_address_valid;
    logic                   write_data_ready  = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   empty;

    entry_t        model_q[$];
    logic [AW-1:0] drained[$];
    int            n_pass  = 0;
    int            n_total = 0;

    sdram_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_write_address   (cpu_write_address),
        .cpu_write_data      (cpu_write_data),
        .cpu_write_valid     (cpu_write_valid),
        .cpu_write_ready     (cpu_write_ready),
        .cpu_read_address    (cpu_read_address),
        .cpu_read_hazard     (cpu_read_hazard),
        .write_address       (write_address),
        .write_data          (write_data),
        .write_address_valid (write_address_valid),
        .write_data_ready    (write_data_ready),
        .occupancy           (occupancy),
        .empty               (empty)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic model_hazard(input logic [AW-1:0] ra);
        foreach (model_q[i]) if (model_q[i].addr == ra) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive at the falling edge, check outputs against the model,
    // then advance the model by what the coming rising edge should do.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rdy, input logic [AW-1:0] ra, input string tag);
        logic can_push;
        @(negedge clk);
        cpu_write_valid   = v;
        cpu_write_address = a;
        cpu_write_data    = d;
        write_data_ready  = rdy;
        cpu_read_address  = ra;
        #1;
        check({tag, ":valid"},  64'(write_address_valid), 64'(model_q.size() != 0));
        check({tag, ":occ"},    64'(occupancy),           64'(model_q.size()));
        check({tag, ":empty"},  64'(empty),               64'(model_q.size() == 0));
        check({tag, ":ready"},  64'(cpu_write_ready),     64'(model_q.size() < DEPTH));
        check({tag, ":hazard"}, 64'(cpu_read_hazard),     64'(model_hazard(ra)));
        if (model_q.size() != 0) begin
            check({tag, ":addr"}, 64'(write_address), 64'(model_q[0].addr));
            check({tag, ":data"}, 64'(write_data),    64'(model_q[0].data));
        end
        can_push = v && (model_q.size() < DEPTH);
        if (rdy && model_q.size() != 0) begin
            drained.push_back(write_address);
            void'(model_q.pop_front());
        end
        if (can_push) model_q.push_back('{addr: a, data: d});
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 50 && model_q.size() != 0; c++) step(1'b0, '0, '0, 1'b1, '0, tag);
        step(1'b0, '0, '0, 1'b0, '0, tag);
        check({tag, ":drained_empty"}, 64'(empty), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":valid"},  64'(write_address_valid), 64'd0);
        check({tag, ":addr"},   64'(write_address),       64'd0);
        check({tag, ":data"},   64'(write_data),          64'd0);
        check({tag, ":occ"},    64'(occupancy),           64'd0);
        check({tag, ":empty"},  64'(empty),               64'd1);
        check({tag, ":ready"},  64'(cpu_write_ready),     64'd1);
        check({tag, ":hazard"}, 64'(cpu_read_hazard),     64'd0);
    endtask

    initial begin
        int pushed;
        logic v;
        logic rdy;
        logic [AW-1:0] a;
        logic [AW-1:0] ra;

        #1;
        check_reset_outputs("por");
        #2 reset = 1'b0;

        // Reset with the clock stopped must clear pending entries immediately.
        step(1'b1, 32'h0000_0A00, 32'h1111_2222, 1'b0, 32'h0000_0A00, "pre_rst0");
        step(1'b1, 32'h0000_0A04, 32'h3333_4444, 1'b0, 32'h0000_0A00, "pre_rst1");
        step(1'b0, '0, '0, 1'b0, 32'h0000_0A00, "pre_rst2");
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        clk_en = 1'b0;
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        reset = 1'b0;
        model_q.delete();
        #1 clk_en = 1'b1;

        // Single write: visible one cycle after push, popped two cycles after valid rises.
        step(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, '0, "single_push");
        step(1'b0, '0, '0, 1'b0, '0, "single_wait");
        check("single_valid", 64'(write_address_valid), 64'd1);
        check("single_addr",  64'(write_address),       64'h0000_0100);
        check("single_data",  64'(write_data),          64'hDEAD_BEEF);
        step(1'b0, '0, '0, 1'b1, '0, "single_pop");
        step(1'b0, '0, '0, 1'b0, '0, "single_after");
        check("single_empty", 64'(empty), 64'd1);

        // Fill: five pushes into four slots, then a full-cycle pop must still refuse a push.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b0, '0, "fill");
        step(1'b0, '0, '0, 1'b0, '0, "fill_hold");
        check("fill_occ",   64'(occupancy),       64'd4);
        check("fill_ready", 64'(cpu_write_ready), 64'd0);
        step(1'b1, 32'h300, 32'h0BAD_0BAD, 1'b1, '0, "full_pop_push");
        step(1'b0, '0, '0, 1'b0, '0, "after_full_pop");
        check("after_pop_ready", 64'(cpu_write_ready), 64'd1);
        check("after_pop_occ",   64'(occupancy),       64'd3);
        drain("fill_drain");

        // Order and wrap: addresses 0..10 with random drain gaps.
        drained.delete();
        pushed = 0;
        for (int c = 0; c < 300 && (pushed < 11 || model_q.size() != 0); c++) begin
            v   = (pushed < 11);
            rdy = 1'($urandom_range(0, 1));
            if (v && model_q.size() < DEPTH) begin
                step(1'b1, AW'(pushed), $urandom, rdy, '0, "order");
                pushed++;
            end else begin
                step(v, AW'(pushed), $urandom, rdy, '0, "order");
            end
        end
        check("order_count", 64'(drained.size()), 64'd11);
        for (int i = 0; i < 11 && i < drained.size(); i++) check("order_seq", 64'(drained[i]), 64'(i));

        // Hazard detection.
        step(1'b1, 32'h40, 32'hA, 1'b0, 32'h80, "hz_push40");
        step(1'b1, 32'h80, 32'hB, 1'b0, 32'h80, "hz_push80");
        step(1'b0, '0, '0, 1'b0, 32'h80, "hz_80");
        check("hz_80_hit", 64'(cpu_read_hazard), 64'd1);
        step(1'b0, '0, '0, 1'b0, 32'hC0, "hz_c0");
        check("hz_c0_miss", 64'(cpu_read_hazard), 64'd0);
        step(1'b0, '0, '0, 1'b1, 32'h80, "hz_pop40");
        check("hz_pop40_hit", 64'(cpu_read_hazard), 64'd1);
        step(1'b0, '0, '0, 1'b1, 32'h80, "hz_pop80");
        check("hz_popping_hit", 64'(cpu_read_hazard), 64'd1);
        step(1'b0, '0, '0, 1'b0, 32'h80, "hz_gone");
        check("hz_gone_miss", 64'(cpu_read_hazard), 64'd0);
        step(1'b1, 32'h100, 32'hC, 1'b0, 32'h100, "hz_push100");
        check("hz_same_cycle", 64'(cpu_read_hazard), 64'd0);
        step(1'b0, '0, '0, 1'b0, 32'h100, "hz_next");
        check("hz_next_cycle", 64'(cpu_read_hazard), 64'd1);
        drain("hz_drain");

        // Reset while the head write is in progress at the adapter.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(i), $urandom, 1'b0, '0, "mid_fill");
        step(1'b0, '0, '0, 1'b0, 32'h500, "mid_head");
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        model_q.delete();
        step(1'b1, 32'h600, 32'h6666_6666, 1'b0, '0, "post_rst_push");
        step(1'b0, '0, '0, 1'b0, '0, "post_rst_wait");
        check("post_rst_addr", 64'(write_address), 64'h600);
        check("post_rst_occ",  64'(occupancy),     64'd1);
        step(1'b0, '0, '0, 1'b1, '0, "post_rst_pop");
        drain("post_rst_drain");

        // Random traffic over a small address set so hazards and duplicates occur.
        for (int c = 0; c < 300; c++) begin
            a  = 32'h10 * 32'($urandom_range(1, 4));
            ra = 32'h10 * 32'($urandom_range(1, 4));
            step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), ra, "rand");
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
